// File: rtl/shift_sub_divider.sv
// shift_sub_divider
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Each step shifts {R,Q} left by one and tries R - D through a ripple chain
// of full-adder cells (A + ~B + 1). The carry-out of that chain is the
// "no borrow" flag, which selects between the difference and the shifted R.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; operands are sampled on the accepting edge
// RUN   | one shift/subtract step per cycle, WIDTH steps in total
// FIN   | results valid, done pulses for this single cycle

module shift_sub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Working registers. R carries one extra bit because the shifted partial
    // remainder can reach just under twice the divisor before subtraction.
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign d_ext   = {1'b0, d_reg};

    // Trial subtraction: ripple of full-adder cells computing r_shift + ~d_ext + 1.
    always_comb begin
        logic carry;
        logic b_inv;
        diff  = '0;
        carry = 1'b1;
        b_inv = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            b_inv   = ~d_ext[i];
            diff[i] = r_shift[i] ^ b_inv ^ carry;
            carry   = (r_shift[i] & b_inv) | (r_shift[i] & carry) | (b_inv & carry);
        end
        no_borrow = carry;
    end

    // Restoring step: keep the difference only when the subtraction did not borrow.
    always_comb begin
        r_next = no_borrow ? diff : r_shift;
        q_next = {q_reg[WIDTH-2:0], no_borrow};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; busy and done are pure functions of the state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count_reg == '0) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and result registers. Results only move on the edge that
    // enters FIN, so the internal R/Q never show through while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count_reg   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_reg     <= '0;
                            q_reg     <= dividend;
                            d_reg     <= divisor;
                            count_reg <= CW'(WIDTH - 1);
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_reg     <= r_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == '0) begin
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
